// File: rtl/mips_fetch_buffer.sv
// Instruction prefetch buffer: fetches sequential 16-bit words from
// instruction memory into a small FIFO. It handles core redirects by
// flushing the FIFO. A response that is still in flight when a redirect
// arrives is drained and then dropped.
module mips_fetch_buffer #(
    parameter int PC_WIDTH   = 16,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        mem_req,
    output logic [PC_WIDTH-1:0]         mem_addr,
    input  logic                        mem_ack,
    input  logic [DATA_WIDTH-1:0]       mem_rdata,
    output logic                        instr_valid,
    output logic [DATA_WIDTH-1:0]       instr_out,
    output logic [PC_WIDTH-1:0]         instr_pc,
    input  logic                        instr_ready,
    input  logic                        redirect,
    input  logic [PC_WIDTH-1:0]         redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0]  buf_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
    // Address of the request still in flight while its response is discarded.
    logic [PC_WIDTH-1:0]    hold_pc_q, hold_pc_d;
    logic [CW-1:0]          count_q, count_d;
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic                   mem_req_q;
    logic [PC_WIDTH-1:0]    mem_addr_q;
    logic [PC_WIDTH-1:0]    pc_mem_q  [DEPTH];
    logic [DATA_WIDTH-1:0]  dat_mem_q [DEPTH];

    logic                   push_s;
    logic                   pop_s;
    logic [PC_WIDTH-1:0]    redirect_al_s;

    assign redirect_al_s = {redirect_pc[PC_WIDTH-1:1], 1'b0};
    assign instr_valid   = (count_q != '0) && !redirect;
    assign pop_s         = instr_valid && instr_ready;
    assign push_s        = (state_q == ST_FETCH) && mem_ack && !redirect;
    assign instr_out     = dat_mem_q[rd_ptr_q];
    assign instr_pc      = pc_mem_q[rd_ptr_q];
    assign buf_count     = count_q;
    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_addr_q;

    // Occupancy after this cycle's flush, push and pop.
    always_comb begin
        count_d = count_q;
        if (redirect) begin
            count_d = '0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Fetch FSM next state and next fetch address.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        hold_pc_d  = hold_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_al_s;
                    state_d    = ST_FETCH;
                end else if (count_d < CW'(DEPTH)) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (redirect) begin
                    fetch_pc_d = redirect_al_s;
                    if (mem_ack) begin
                        state_d = ST_FETCH;
                    end else begin
                        // Keep presenting the old address until it is acked.
                        hold_pc_d = fetch_pc_q;
                        state_d   = ST_DISCARD;
                    end
                end else if (mem_ack) begin
                    fetch_pc_d = fetch_pc_q + PC_WIDTH'(2);
                    state_d    = (count_d < CW'(DEPTH)) ? ST_FETCH : ST_IDLE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                if (redirect) begin
                    fetch_pc_d = redirect_al_s;
                end else begin
                    fetch_pc_d = fetch_pc_q;
                end
                // The in-flight response retires the discard regardless of redirect.
                if (mem_ack) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_DISCARD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers: FSM state, PCs, FIFO pointers, occupancy and registered memory outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= '0;
            hold_pc_q  <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            hold_pc_q  <= hold_pc_d;
            count_q    <= count_d;
            mem_req_q  <= (state_d != ST_IDLE);
            mem_addr_q <= (state_d == ST_DISCARD) ? hold_pc_d : fetch_pc_d;
            if (redirect) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_s) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end else begin
                    wr_ptr_q <= wr_ptr_q;
                end
                if (pop_s) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end else begin
                    rd_ptr_q <= rd_ptr_q;
                end
            end
        end
    end

    // FIFO storage: each entry holds a fetched word and its byte address.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]  <= '0;
                dat_mem_q[i] <= '0;
            end
        end else if (push_s) begin
            pc_mem_q[wr_ptr_q]  <= fetch_pc_q;
            dat_mem_q[wr_ptr_q] <= mem_rdata;
        end else begin
            pc_mem_q[wr_ptr_q]  <= pc_mem_q[wr_ptr_q];
            dat_mem_q[wr_ptr_q] <= dat_mem_q[wr_ptr_q];
        end
    end

endmodule

// File: tb/tb_mips_fetch_buffer.sv
// Bench for mips_fetch_buffer. A scoreboard models the instruction stream
// as a queue of {pc, data}. Memory contents are a fixed function of the
// address. Directed scenarios are followed by a randomized run.
module tb_mips_fetch_buffer;

    localparam int PW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_req;
    logic [PW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          instr_valid;
    logic [DW-1:0] instr_out;
    logic [PW-1:0] instr_pc;
    logic          instr_ready;
    logic          redirect;
    logic [PW-1:0] redirect_pc;
    logic [CW-1:0] buf_count;

    int total = 0;
    int bad   = 0;
    int pops  = 0;

    // Reference model state.
    logic [31:0]   sb_q[$];
    logic [PW-1:0] m_pc;
    logic          m_disc;
    logic [PW-1:0] m_held;

    mips_fetch_buffer #(.PC_WIDTH(PW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .buf_count(buf_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    assign mem_rdata = mem_fn(mem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every cycle against the model, then advances the model.
    initial begin
        logic [31:0] e;
        m_pc   = '0;
        m_disc = 1'b0;
        m_held = '0;
        forever begin
            @(negedge clk);
            check("count", 32'(buf_count), 32'(sb_q.size()));
            check("valid", 32'(instr_valid), 32'((sb_q.size() != 0) && !redirect));
            if (rst) begin
                sb_q.delete();
                m_pc   = '0;
                m_disc = 1'b0;
            end else begin
                if (mem_req) begin
                    check("addr", 32'(mem_addr), 32'(m_disc ? m_held : m_pc));
                    if (!m_disc) check("room", 32'(sb_q.size() < DEPTH), 32'd1);
                end
                if (instr_valid && instr_ready && !redirect && sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("pop_pc", 32'(instr_pc), 32'(e[31:16]));
                    check("pop_data", 32'(instr_out), 32'(e[15:0]));
                    pops++;
                end
                if (redirect) begin
                    sb_q.delete();
                    if (mem_req && !mem_ack && !m_disc) begin
                        m_disc = 1'b1;
                        m_held = m_pc;
                    end else if (mem_req && mem_ack) begin
                        m_disc = 1'b0;
                    end
                    m_pc = {redirect_pc[PW-1:1], 1'b0};
                end else if (mem_req && mem_ack) begin
                    if (m_disc) begin
                        m_disc = 1'b0;
                    end else begin
                        sb_q.push_back({m_pc, mem_fn(m_pc)});
                        m_pc = m_pc + 16'd2;
                    end
                end
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        logic [15:0] wrap_exp [4];
        wrap_exp[0] = 16'hFFFC; wrap_exp[1] = 16'hFFFE;
        wrap_exp[2] = 16'h0000; wrap_exp[3] = 16'h0002;
        rst = 1'b1; mem_ack = 1'b0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 16'h0000;

        // Reset state and restart.
        repeat (3) cyc();
        @(negedge clk);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_out", 32'(instr_out), 32'd0);
        check("rst_pc", 32'(instr_pc), 32'd0);
        check("rst_count", 32'(buf_count), 32'd0);
        cyc(); rst = 1'b0;
        @(negedge clk); check("first_idle", 32'(mem_req), 32'd0);
        cyc();
        @(negedge clk); check("first_req", 32'(mem_req), 32'd1);
        check("first_addr", 32'(mem_addr), 32'd0);

        // Fill with core stalled, then drain in order.
        cyc(); mem_ack = 1'b1; instr_ready = 1'b0;
        repeat (8) cyc();
        @(negedge clk);
        check("full_count", 32'(buf_count), 32'd4);
        check("full_req", 32'(mem_req), 32'd0);
        check("full_head", 32'(instr_pc), 32'd0);
        cyc(); instr_ready = 1'b1;
        repeat (12) cyc();

        // Redirect while a request is pending; response is held then dropped.
        redirect = 1'b1; redirect_pc = 16'h0006; mem_ack = 1'b1;
        cyc(); redirect = 1'b0; mem_ack = 1'b0;
        @(negedge clk); check("pend_addr0", 32'(mem_addr), 32'h6);
        cyc(); redirect = 1'b1; redirect_pc = 16'h0100;
        @(negedge clk); check("pend_addr1", 32'(mem_addr), 32'h6);
        cyc(); redirect = 1'b0;
        @(negedge clk); check("disc_addr0", 32'(mem_addr), 32'h6);
        check("disc_req", 32'(mem_req), 32'd1);
        cyc();
        @(negedge clk); check("disc_addr1", 32'(mem_addr), 32'h6);
        cyc(); mem_ack = 1'b1;
        @(negedge clk); check("disc_addr2", 32'(mem_addr), 32'h6);
        cyc(); mem_ack = 1'b0;
        @(negedge clk); check("after_disc", 32'(mem_addr), 32'h100);
        check("after_disc_v", 32'(instr_valid), 32'd0);

        // Redirect + ack + pop together, odd target.
        cyc(); instr_ready = 1'b0; mem_ack = 1'b1;
        cyc();
        cyc(); redirect = 1'b1; redirect_pc = 16'h0101; instr_ready = 1'b1;
        @(negedge clk); check("pre_flush_cnt", 32'(buf_count), 32'd2);
        check("redir_valid", 32'(instr_valid), 32'd0);
        cyc(); redirect = 1'b0; mem_ack = 1'b0;
        @(negedge clk); check("flush_cnt", 32'(buf_count), 32'd0);
        check("flush_addr", 32'(mem_addr), 32'h100);

        // Address wrap.
        cyc(); redirect = 1'b1; redirect_pc = 16'hFFFC; mem_ack = 1'b1; instr_ready = 1'b1;
        cyc(); redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); check("wrap_addr", 32'(mem_addr), 32'(wrap_exp[i]));
            cyc();
        end

        // Reset in FETCH with three entries buffered.
        redirect = 1'b1; redirect_pc = 16'h0000; instr_ready = 1'b0;
        cyc(); redirect = 1'b0;
        repeat (3) cyc();
        rst = 1'b1; redirect = 1'b1; redirect_pc = 16'h0200; instr_ready = 1'b1;
        @(negedge clk); check("pre_rst_cnt", 32'(buf_count), 32'd3);
        check("pre_rst_req", 32'(mem_req), 32'd1);
        cyc(); rst = 1'b0; redirect = 1'b0;
        @(negedge clk);
        check("post_rst_req", 32'(mem_req), 32'd0);
        check("post_rst_cnt", 32'(buf_count), 32'd0);
        check("post_rst_v", 32'(instr_valid), 32'd0);
        cyc();
        @(negedge clk); check("restart_req", 32'(mem_req), 32'd1);
        check("restart_addr", 32'(mem_addr), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst         = ($urandom_range(0, 199) == 0);
            mem_ack     = ($urandom_range(0, 9) < 6);
            instr_ready = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = 16'($urandom);
        end
        cyc(); rst = 1'b0; redirect = 1'b0; mem_ack = 1'b1; instr_ready = 1'b1;
        repeat (20) cyc();
        @(negedge clk);
        check("progress", 32'(pops > 500), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
